// File: rtl/apb_pkg.sv
// Shared definitions for the APB master: transfer state encoding and default bus widths.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus the APB bus, bundled for the APB master and its environment.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_timeout_cnt.sv
// Counts consecutive stalled ACCESS cycles; expired is high in the cycle that would make the
// count reach LIMIT, so the master can abort on that same edge.
module apb_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt;

    assign expired = count_en && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (count_en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB master: turns one command at a time into a SETUP/ACCESS transfer and returns a one-cycle
// response; supports back-to-back commands and an optional ACCESS-wait timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic          pclk,
    input logic          rst,
    apb_master_if.master bus
);

    apb_state_e state;
    logic       accept;
    logic       cnt_clear;
    logic       cnt_en;
    logic       timeout_hit;

    // Ready is combinational so a new command can ride the completion edge of the current one.
    assign bus.cmd_ready = !rst && ((state == IDLE) || ((state == ACCESS) && bus.pready));
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign cnt_clear     = accept;
    assign cnt_en        = (state == ACCESS) && !bus.pready;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            apb_timeout_cnt #(
                .LIMIT(TIMEOUT_CYCLES)
            ) u_timeout_cnt (
                .clk     (pclk),
                .rst     (rst),
                .clear   (cnt_clear),
                .count_en(cnt_en),
                .expired (timeout_hit)
            );
        end else begin : g_no_timeout
            logic unused_cnt;
            assign unused_cnt  = cnt_clear ^ cnt_en;
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge pclk) begin
        if (rst) begin
            state         <= IDLE;
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.pwrite    <= 1'b0;
            bus.paddr     <= {ADDR_WIDTH{1'b0}};
            bus.pwdata    <= {DATA_WIDTH{1'b0}};
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= {DATA_WIDTH{1'b0}};
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= SETUP;
                        bus.psel    <= 1'b1;
                        bus.penable <= 1'b0;
                        bus.pwrite  <= bus.cmd_write;
                        bus.paddr   <= bus.cmd_addr;
                        bus.pwdata  <= bus.cmd_wdata;
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    bus.penable <= 1'b1;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= bus.pslverr;
                        bus.rsp_rdata <= bus.pwrite ? {DATA_WIDTH{1'b0}} : bus.prdata;
                        if (accept) begin
                            state       <= SETUP;
                            bus.penable <= 1'b0;
                            bus.pwrite  <= bus.cmd_write;
                            bus.paddr   <= bus.cmd_addr;
                            bus.pwdata  <= bus.cmd_wdata;
                        end else begin
                            state       <= IDLE;
                            bus.psel    <= 1'b0;
                            bus.penable <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        // Abort: the slave never answered, report an error with no data.
                        state         <= IDLE;
                        bus.psel      <= 1'b0;
                        bus.penable   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= {DATA_WIDTH{1'b0}};
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.psel    <= 1'b0;
                    bus.penable <= 1'b0;
                end
            endcase
        end
    end

endmodule
